// File: rtl/fib_lookup_scheduler.sv
// ============================================================================
//  Module   : fib_lookup_scheduler
//  Purpose  : Round-robin, credit-gated name issue into the FIB lookup pipeline
//             with an in-order show-ahead response FIFO.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fib_lookup_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int NAME_W       = 1024,
    parameter int POINTER_SIZE = 16,
    parameter int RESP_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid_in,
    output logic [NUM_REQ-1:0]                req_ready_out,
    input  logic [NUM_REQ*NAME_W-1:0]         req_name_in,
    output logic                              pipe_valid_out,
    output logic [NAME_W-1:0]                 pipe_name_out,
    output logic [$clog2(NUM_REQ)-1:0]        pipe_tag_out,
    input  logic                              result_valid_in,
    input  logic [$clog2(NUM_REQ)-1:0]        result_tag_in,
    input  logic                              result_match_in,
    input  logic [POINTER_SIZE-1:0]           result_ptr_in,
    output logic                              resp_valid_out,
    input  logic                              resp_ready_in,
    output logic [$clog2(NUM_REQ)-1:0]        resp_id_out,
    output logic                              resp_match_out,
    output logic [POINTER_SIZE-1:0]           resp_ptr_out,
    output logic [$clog2(RESP_DEPTH):0]       inflight_out,
    output logic                              err_out
);

    localparam int c_TAG_W = $clog2(NUM_REQ);
    localparam int c_PTR_W = $clog2(RESP_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_ENT_W = c_TAG_W + 1 + POINTER_SIZE;
    localparam logic [c_CNT_W:0] c_DEPTH = (c_CNT_W + 1)'(RESP_DEPTH);

    logic [c_TAG_W-1:0] r_rrPtr;
    logic [c_CNT_W-1:0] r_inflight;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_PTR_W-1:0] r_rdPtr;
    logic               r_err;
    logic               r_pipeValid;
    logic [NAME_W-1:0]  r_pipeName;
    logic [c_TAG_W-1:0] r_pipeTag;
    logic [c_ENT_W-1:0] r_mem [RESP_DEPTH];

    logic [c_CNT_W:0]   w_used;
    logic               w_canIssue;
    logic               w_found;
    logic [c_TAG_W-1:0] w_grantIdx;
    logic               w_hs;
    logic               w_push;
    logic               w_pop;
    logic               w_resErr;

    // Every issued name owns one FIFO slot until its response is popped.
    assign w_used     = {1'b0, r_inflight} + {1'b0, r_count};
    assign w_canIssue = !rst && (w_used < c_DEPTH);

    always_comb begin
        logic [c_TAG_W-1:0] v_idx;
        w_found    = 1'b0;
        w_grantIdx = r_rrPtr;
        v_idx      = r_rrPtr;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = r_rrPtr + c_TAG_W'(k);
            if (!w_found && req_valid_in[v_idx]) begin
                w_found    = 1'b1;
                w_grantIdx = v_idx;
            end
        end
    end

    assign w_hs = w_canIssue && w_found;

    always_comb begin
        req_ready_out = '0;
        if (w_hs) begin
            req_ready_out[w_grantIdx] = 1'b1;
        end
    end

    assign w_pop    = (r_count != '0) && resp_ready_in;
    assign w_push   = result_valid_in && (r_inflight != '0);
    assign w_resErr = result_valid_in && (r_inflight == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rrPtr     <= '0;
            r_inflight  <= '0;
            r_count     <= '0;
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_err       <= 1'b0;
            r_pipeValid <= 1'b0;
        end else begin
            r_pipeValid <= w_hs;
            if (w_hs) begin
                r_rrPtr <= w_grantIdx + 1'b1;
            end
            case ({w_hs, w_push})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_resErr) begin
                r_err <= 1'b1;
            end
        end
    end

    // Payload registers carry no reset; they are qualified by the valid state.
    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_pipeName <= req_name_in[w_grantIdx*NAME_W +: NAME_W];
            r_pipeTag  <= w_grantIdx;
        end
        if (w_push) begin
            r_mem[r_wrPtr] <= {result_tag_in, result_match_in, result_ptr_in};
        end
    end

    assign pipe_valid_out = r_pipeValid;
    assign pipe_name_out  = r_pipeName;
    assign pipe_tag_out   = r_pipeTag;
    assign resp_valid_out = (r_count != '0);
    assign {resp_id_out, resp_match_out, resp_ptr_out} = r_mem[r_rdPtr];
    assign inflight_out   = r_inflight;
    assign err_out        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_fib_lookup_scheduler.sv
// ============================================================================
//  Module   : tb_fib_lookup_scheduler
//  Purpose  : Directed and random stimulus against a queue-based scheduler model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fib_lookup_scheduler;

    localparam int NUM_REQ = 4;
    localparam int NAME_W  = 1024;
    localparam int PS      = 16;
    localparam int DEPTH   = 4;
    localparam int TAG_W   = 2;
    localparam int CNT_W   = 3;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             match;
        logic [PS-1:0]    ptr;
    } resp_t;

    typedef struct {
        int tag;
        int due;
    } pend_t;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid_in;
    logic [NUM_REQ-1:0]        req_ready_out;
    logic [NUM_REQ*NAME_W-1:0] req_name_in;
    logic                      pipe_valid_out;
    logic [NAME_W-1:0]         pipe_name_out;
    logic [TAG_W-1:0]          pipe_tag_out;
    logic                      result_valid_in;
    logic [TAG_W-1:0]          result_tag_in;
    logic                      result_match_in;
    logic [PS-1:0]             result_ptr_in;
    logic                      resp_valid_out;
    logic                      resp_ready_in;
    logic [TAG_W-1:0]          resp_id_out;
    logic                      resp_match_out;
    logic [PS-1:0]             resp_ptr_out;
    logic [CNT_W-1:0]          inflight_out;
    logic                      err_out;

    fib_lookup_scheduler #(
        .NUM_REQ(NUM_REQ), .NAME_W(NAME_W), .POINTER_SIZE(PS), .RESP_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out), .req_name_in(req_name_in),
        .pipe_valid_out(pipe_valid_out), .pipe_name_out(pipe_name_out), .pipe_tag_out(pipe_tag_out),
        .result_valid_in(result_valid_in), .result_tag_in(result_tag_in),
        .result_match_in(result_match_in), .result_ptr_in(result_ptr_in),
        .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in),
        .resp_id_out(resp_id_out), .resp_match_out(resp_match_out), .resp_ptr_out(resp_ptr_out),
        .inflight_out(inflight_out), .err_out(err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus controls
    logic               rstD;
    logic [NUM_REQ-1:0] validD;
    logic [NAME_W-1:0]  namesD [NUM_REQ];
    logic               respReadyD;
    int                 fixedLat;
    bit                 forceSpur;
    int                 spurRate;
    bit                 checkEn;

    // Model state
    int                 lastWin;
    int                 mInflight;
    resp_t              mq[$];
    bit                 mErr;
    bit                 mPrevHs;
    int                 mPrevTag;
    logic [NAME_W-1:0]  mPrevName;
    pend_t              pq[$];
    int                 cyc;
    int                 passed;
    int                 total;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic randNames();
        for (int i = 0; i < NUM_REQ; i++)
            for (int w = 0; w < NAME_W / 32; w++)
                namesD[i][w*32 +: 32] = $urandom;
    endtask

    task automatic step();
        logic [NUM_REQ-1:0] expReady;
        int                 g;
        bit                 hs;
        resp_t              r;
        pend_t              p;
        @(negedge clk);
        rst           = rstD;
        req_valid_in  = validD;
        resp_ready_in = respReadyD;
        for (int i = 0; i < NUM_REQ; i++) req_name_in[i*NAME_W +: NAME_W] = namesD[i];
        result_valid_in = 1'b0;
        result_tag_in   = '0;
        result_match_in = 1'b0;
        result_ptr_in   = '0;
        if (!rstD && pq.size() > 0 && pq[0].due <= cyc) begin
            result_valid_in = 1'b1;
            result_tag_in   = TAG_W'(pq[0].tag);
            result_match_in = 1'($urandom);
            result_ptr_in   = PS'($urandom);
            void'(pq.pop_front());
        end else if (!rstD && pq.size() == 0 &&
                     (forceSpur || $urandom_range(999) < 32'(spurRate))) begin
            result_valid_in = 1'b1;
            result_tag_in   = TAG_W'($urandom);
            result_match_in = 1'($urandom);
            result_ptr_in   = PS'($urandom);
        end
        #1;
        expReady = '0;
        g = 0;
        if (!rstD && mInflight + mq.size() < DEPTH) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int i;
                i = (lastWin + 1 + k) % NUM_REQ;
                if (validD[i] && expReady == '0) begin
                    expReady[i] = 1'b1;
                    g = i;
                end
            end
        end
        if (checkEn) begin
            check("req_ready", 64'(req_ready_out), 64'(expReady));
            check("pipe_valid", 64'(pipe_valid_out), 64'(mPrevHs));
            if (mPrevHs) begin
                check("pipe_tag", 64'(pipe_tag_out), 64'(mPrevTag));
                total++;
                if (pipe_name_out === mPrevName) passed++;
                else $display("FAIL pipe_name: got %0h expected %0h (low 64 bits, cycle %0d)",
                              pipe_name_out[63:0], mPrevName[63:0], cyc);
            end
            check("resp_valid", 64'(resp_valid_out), 64'(mq.size() > 0));
            if (mq.size() > 0)
                check("resp_head", 64'({resp_id_out, resp_match_out, resp_ptr_out}), 64'(mq[0]));
            check("inflight", 64'(inflight_out), 64'(mInflight));
            check("err", 64'(err_out), 64'(mErr));
        end
        if (rstD) begin
            lastWin   = NUM_REQ - 1;
            mInflight = 0;
            mq.delete();
            pq.delete();
            mErr      = 1'b0;
            mPrevHs   = 1'b0;
        end else begin
            hs = (expReady != '0);
            if (mq.size() > 0 && respReadyD) void'(mq.pop_front());
            if (result_valid_in) begin
                if (mInflight > 0) begin
                    r.tag = result_tag_in; r.match = result_match_in; r.ptr = result_ptr_in;
                    mq.push_back(r);
                    mInflight--;
                end else begin
                    mErr = 1'b1;
                end
            end
            if (hs) begin
                mInflight++;
                lastWin = g;
                p.tag = g;
                p.due = cyc + ((fixedLat > 0) ? fixedLat : int'($urandom_range(10, 1)));
                pq.push_back(p);
                mPrevName = namesD[g];
            end
            mPrevHs  = hs;
            mPrevTag = g;
        end
        cyc++;
    endtask

    task automatic doReset(input int n);
        rstD = 1'b1;
        repeat (n) step();
        rstD = 1'b0;
    endtask

    initial begin
        int hsCount;
        passed = 0; total = 0; cyc = 0;
        lastWin = NUM_REQ - 1; mInflight = 0; mErr = 0; mPrevHs = 0; mPrevTag = 0;
        mPrevName = '0;
        validD = '0; respReadyD = 1'b1; fixedLat = 8; forceSpur = 0; spurRate = 0;
        randNames();
        checkEn = 1'b0;
        rstD = 1'b1;
        step();
        checkEn = 1'b1;
        doReset(2);

        // Reset state
        step();
        check("rst_inflight", 64'(inflight_out), 64'd0);
        check("rst_err", 64'(err_out), 64'd0);
        check("rst_pipe_valid", 64'(pipe_valid_out), 64'd0);
        check("rst_resp_valid", 64'(resp_valid_out), 64'd0);

        // All requesters valid, latency 8
        validD = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr_seq", 64'(req_ready_out), 64'(4'b0001 << k));
        end
        step();
        check("credit_block", 64'(req_ready_out), 64'd0);
        check("pipe_tag_3", 64'(pipe_tag_out), 64'd3);
        repeat (40) begin randNames(); step(); end
        check("no_err_stream", 64'(err_out), 64'd0);

        // Credit exhaustion with consumer stalled
        doReset(1);
        validD = 4'b0100; respReadyD = 1'b0; fixedLat = 2;
        hsCount = 0;
        repeat (10) begin
            step();
            if (req_ready_out[2]) hsCount++;
        end
        check("credit_hs_count", 64'(hsCount), 64'd4);
        check("credit_inflight", 64'(inflight_out), 64'd0);
        respReadyD = 1'b1;
        step();
        check("full_no_ready", 64'(req_ready_out), 64'd0);
        respReadyD = 1'b0;
        step();
        check("pop_reenables", 64'(req_ready_out), 64'(4'b0100));
        step();
        check("pop_one_credit", 64'(req_ready_out), 64'd0);

        // Round-robin restart after skipping
        respReadyD = 1'b1;
        doReset(1);
        fixedLat = 3;
        validD = 4'b0010; step();
        check("grant1", 64'(req_ready_out), 64'(4'b0010));
        validD = 4'b1000; step();
        check("grant3", 64'(req_ready_out), 64'(4'b1000));
        validD = 4'b1111; step();
        check("wrap_to0", 64'(req_ready_out), 64'(4'b0001));
        validD = 4'b0000;
        repeat (10) step();

        // Spurious result
        forceSpur = 1; step();
        forceSpur = 0; step();
        check("spur_err", 64'(err_out), 64'd1);
        check("spur_fifo", 64'(resp_valid_out), 64'd0);
        check("spur_inflight", 64'(inflight_out), 64'd0);
        validD = 4'b0101;
        repeat (6) step();
        check("err_sticky", 64'(err_out), 64'd1);
        validD = 4'b0000;
        repeat (10) step();

        // Reset mid-operation: inflight 3, one buffered response
        doReset(1);
        respReadyD = 1'b0; fixedLat = 4; validD = 4'b0001;
        repeat (5) step();
        rstD = 1'b1;
        step();
        check("pre_rst_inflight", 64'(inflight_out), 64'd3);
        check("pre_rst_fifo", 64'(resp_valid_out), 64'd1);
        rstD = 1'b0; validD = 4'b1111;
        step();
        check("post_rst_inflight", 64'(inflight_out), 64'd0);
        check("post_rst_fifo", 64'(resp_valid_out), 64'd0);
        check("post_rst_err", 64'(err_out), 64'd0);
        check("post_rst_rr", 64'(req_ready_out), 64'(4'b0001));

        // Random traffic
        fixedLat = 0; spurRate = 10;
        repeat (3000) begin
            validD     = NUM_REQ'($urandom);
            respReadyD = ($urandom_range(3) != 0);
            rstD       = ($urandom_range(299) == 0);
            randNames();
            step();
        end
        rstD = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
